maze_two_ctrl: RTL and testbench
================================

Name: maze_two_ctrl

Overview:
- Game-logic stage for maze level two; drives the maze renderer directly downstream of it.
- Tracks the player on an 18x11 tile grid. Tile index = col + 18*row, range 0..197.
- Produces the visited-tile bitmap and the move/hit counter that the renderer draws. Value 255 on the counter makes the renderer paint the whole maze red.
- Enforces the checkpoint order 31 -> 37 -> 113 -> 139 -> 178 and flags completion.

Parameters:
- START_TILE, 19, tile where the player spawns after reset or a restart.
- HIT_FRAMES, 30, number of tick pulses the HIT (red) state lasts.
- PATH_MASK, 198 bits, default = interior path: row 0, row 10, col 0 and col 17 are walls (0), all other tiles are path (1). A 1 means the tile is walkable.

Ports:
- CLK  input  1  system clock
- RST  input  1  reset, synchronous, active-high
- btn_up  input  1  single-cycle move pulse
- btn_down  input  1  single-cycle move pulse
- btn_left  input  1  single-cycle move pulse
- btn_right  input  1  single-cycle move pulse
- tick  input  1  one-cycle frame pulse
- mazestate  output  198  visited-tile bitmap for the renderer
- counter  output  8  move count 0..254; 255 = hit indication
- player_tile  output  8  current tile index
- checkpoint_idx  output  3  number of checkpoints cleared, 0..5
- done  output  1  level complete
- fail_count  output  4  hits since RST, saturating

Behaviour:
- All outputs are registered.
- Reset values:
  - mazestate = only bit START_TILE set
  - counter = 0
  - player_tile = START_TILE
  - checkpoint_idx = 0, done = 0, fail_count = 0
  - state = PLAY
- Internal registers row (4 bits) and col (5 bits) track the player; player_tile equals col + 18*row at all times.
- State PLAY:
  - One move per cycle. If several buttons pulse together, priority is up > down > left > right; the others are dropped.
  - Target tile: up = row-1, down = row+1, left = col-1, right = col+1.
  - A move that would leave the grid (row 0 up, row 10 down, col 0 left, col 17 right) is ignored. No update, no hit.
  - Target with PATH_MASK = 1:
    - player moves
    - mazestate[target] set
    - counter increments, saturating at 254
    - all of this is visible the cycle after the pulse
  - Checkpoint on entry: if target equals checkpoint[checkpoint_idx], checkpoint_idx increments on the same edge. Entering a checkpoint out of order has no effect beyond a normal move.
  - When checkpoint_idx reaches 5, done goes to 1 on that same edge and the state becomes WIN.
  - Target with PATH_MASK = 0 is a hit:
    - player does not move
    - counter = 255 the next cycle
    - fail_count increments, saturating at 15
    - state becomes HIT
    - internal tick counter cleared
- State HIT:
  - All buttons ignored.
  - Each tick increments the tick counter. A tick in the same cycle as the hit does not count.
  - On the edge where the counted tick equals HIT_FRAMES:
    - restart: mazestate, counter, player_tile and checkpoint_idx return to their reset values
    - fail_count is held
    - state becomes PLAY
- State WIN:
  - All buttons ignored; every output frozen.
  - Only RST leaves this state.
- RST has priority over everything in every state, including mid-HIT and same-cycle button pulses. The result is exactly the reset values.
- mazestate bits are never cleared except by restart or RST. Revisiting a tile re-sets its bit, which is harmless, and still counts as a move.
- Tiles with PATH_MASK = 0 never get their mazestate bit set.

Test Plan:
- Reset then idle 10 cycles -> player_tile=19, mazestate has only bit 19 set, counter=0, checkpoint_idx=0, done=0, fail_count=0.
- btn_right pulse, then btn_down pulse -> player_tile=20, counter=1; then player_tile=38, counter=2; mazestate bits {19,20,38} set.
- From tile 19, btn_up (target 1, a wall) -> next cycle counter=255, fail_count=1, player_tile=19. Send 29 ticks -> still HIT. 30th tick -> next cycle counter=0, mazestate only bit 19 set, fail_count=1.
- Walk a legal path visiting 37 before 31 -> checkpoint_idx stays 0 at 37. Then 31 -> 1, 37 -> 2, 113 -> 3, 139 -> 4, 178 -> 5 with done=1. Further button pulses change nothing.
- btn_up, btn_left and btn_right pulsed together at tile 38 -> only up is taken, player_tile=20. 300 legal back-and-forth moves -> counter saturates at 254.
- RST asserted mid-HIT, coincident with a tick and a button pulse -> next cycle all outputs equal reset values, fail_count=0, state PLAY.

Source files
------------

// File: rtl/maze_two_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | maze_two_ctrl : level-two maze game logic (player, visited map, hits)  |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
module maze_two_ctrl #(
    parameter int unsigned  START_TILE = 19,
    parameter int unsigned  HIT_FRAMES = 30,
    parameter logic [197:0] PATH_MASK  = {18'h0, {9{18'h1FFFE}}, 18'h0}
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         btn_left,
    input  logic         btn_right,
    input  logic         tick,
    output logic [197:0] mazestate,
    output logic [7:0]   counter,
    output logic [7:0]   player_tile,
    output logic [2:0]   checkpoint_idx,
    output logic         done,
    output logic [3:0]   fail_count
);

    localparam logic [3:0]   START_ROW = 4'(START_TILE / 18);
    localparam logic [4:0]   START_COL = 5'(START_TILE % 18);
    localparam logic [197:0] MS_RESET  = 198'(1) << START_TILE;
    localparam int           TCW       = $clog2(HIT_FRAMES + 1);
    localparam logic [TCW-1:0] TICK_LAST = TCW'(HIT_FRAMES - 1);

    typedef enum logic [1:0] {S_PLAY = 2'd0, S_HIT = 2'd1, S_WIN = 2'd2} state_t;

    state_t         state_q, state_d;
    logic [3:0]     row_q, row_d;
    logic [4:0]     col_q, col_d;
    logic [7:0]     tile_q, tile_d;
    logic [197:0]   mazestate_q, mazestate_d;
    logic [7:0]     counter_q, counter_d;
    logic [2:0]     ckpt_q, ckpt_d;
    logic           done_q, done_d;
    logic [3:0]     fail_q, fail_d;
    logic [TCW-1:0] tick_q, tick_d;

    logic [3:0]     tgt_row;
    logic [4:0]     tgt_col;
    logic [7:0]     tgt_tile;
    logic           mv_valid;

    function automatic logic [7:0] cp_tile(input logic [2:0] idx);
        case (idx)
            3'd0:    cp_tile = 8'd31;
            3'd1:    cp_tile = 8'd37;
            3'd2:    cp_tile = 8'd113;
            3'd3:    cp_tile = 8'd139;
            3'd4:    cp_tile = 8'd178;
            default: cp_tile = 8'hFF;
        endcase
    endfunction

    // Highest-priority button picks the direction; an off-grid move is dropped.
    always_comb begin
        tgt_row  = row_q;
        tgt_col  = col_q;
        mv_valid = 1'b0;
        if (btn_up) begin
            if (row_q != 4'd0) begin
                tgt_row  = row_q - 4'd1;
                mv_valid = 1'b1;
            end
        end else if (btn_down) begin
            if (row_q != 4'd10) begin
                tgt_row  = row_q + 4'd1;
                mv_valid = 1'b1;
            end
        end else if (btn_left) begin
            if (col_q != 5'd0) begin
                tgt_col  = col_q - 5'd1;
                mv_valid = 1'b1;
            end
        end else if (btn_right) begin
            if (col_q != 5'd17) begin
                tgt_col  = col_q + 5'd1;
                mv_valid = 1'b1;
            end
        end
        tgt_tile = 8'(tgt_col) + 8'(tgt_row) * 8'd18;
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        tile_d      = tile_q;
        mazestate_d = mazestate_q;
        counter_d   = counter_q;
        ckpt_d      = ckpt_q;
        done_d      = done_q;
        fail_d      = fail_q;
        tick_d      = tick_q;
        case (state_q)
            S_PLAY: begin
                if (mv_valid) begin
                    if (PATH_MASK[tgt_tile]) begin
                        row_d                 = tgt_row;
                        col_d                 = tgt_col;
                        tile_d                = tgt_tile;
                        mazestate_d[tgt_tile] = 1'b1;
                        counter_d = (counter_q >= 8'd254) ? 8'd254 : counter_q + 8'd1;
                        if (tgt_tile == cp_tile(ckpt_q)) begin
                            ckpt_d = ckpt_q + 3'd1;
                            if (ckpt_q == 3'd4) begin
                                done_d  = 1'b1;
                                state_d = S_WIN;
                            end
                        end
                    end else begin
                        counter_d = 8'd255;
                        fail_d    = (fail_q == 4'd15) ? 4'd15 : fail_q + 4'd1;
                        tick_d    = '0;
                        state_d   = S_HIT;
                    end
                end
            end
            S_HIT: begin
                if (tick) begin
                    if (tick_q == TICK_LAST) begin
                        row_d       = START_ROW;
                        col_d       = START_COL;
                        tile_d      = 8'(START_TILE);
                        mazestate_d = MS_RESET;
                        counter_d   = 8'd0;
                        ckpt_d      = 3'd0;
                        tick_d      = '0;
                        state_d     = S_PLAY;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            S_WIN: begin
            end
            default: state_d = S_PLAY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_PLAY;
            row_q       <= START_ROW;
            col_q       <= START_COL;
            tile_q      <= 8'(START_TILE);
            mazestate_q <= MS_RESET;
            counter_q   <= 8'd0;
            ckpt_q      <= 3'd0;
            done_q      <= 1'b0;
            fail_q      <= 4'd0;
            tick_q      <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            tile_q      <= tile_d;
            mazestate_q <= mazestate_d;
            counter_q   <= counter_d;
            ckpt_q      <= ckpt_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            tick_q      <= tick_d;
        end
    end

    assign mazestate      = mazestate_q;
    assign counter        = counter_q;
    assign player_tile    = tile_q;
    assign checkpoint_idx = ckpt_q;
    assign done           = done_q;
    assign fail_count     = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_maze_two_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_maze_two_ctrl : directed scoreboard bench for maze_two_ctrl         |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_maze_two_ctrl;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic         tick = 1'b0;
    logic [197:0] mazestate;
    logic [7:0]   counter;
    logic [7:0]   player_tile;
    logic [2:0]   checkpoint_idx;
    logic         done;
    logic [3:0]   fail_count;

    maze_two_ctrl dut (
        .CLK           (CLK),
        .RST           (RST),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .tick          (tick),
        .mazestate     (mazestate),
        .counter       (counter),
        .player_tile   (player_tile),
        .checkpoint_idx(checkpoint_idx),
        .done          (done),
        .fail_count    (fail_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [197:0] ms;
        logic [7:0]   cnt;
        logic [7:0]   tile;
        logic [2:0]   ck;
        logic         dn;
        logic [3:0]   fc;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;

    // Reference model: tile-based, walls derived from row/col by division.
    logic [197:0] m_ms;
    int           m_tile, m_cnt, m_ck, m_fc, m_st, m_tk;
    bit           m_dn;
    int           cps[5] = '{31, 37, 113, 139, 178};

    function automatic bit walkable(input int t);
        int r = t / 18;
        int c = t % 18;
        return (r >= 1) && (r <= 9) && (c >= 1) && (c <= 16);
    endfunction

    task automatic model_reset(input bit keep_fail);
        m_ms = '0;
        m_ms[19] = 1'b1;
        m_tile = 19;
        m_cnt = 0;
        m_ck = 0;
        m_dn = 1'b0;
        m_st = 0;
        m_tk = 0;
        if (!keep_fail) m_fc = 0;
    endtask

    task automatic model_update(input bit u, d, l, r, tk, rs);
        int row, col, tgt;
        if (rs) begin
            model_reset(1'b0);
        end else if (m_st == 0) begin
            row = m_tile / 18;
            col = m_tile % 18;
            tgt = -1;
            if (u)      begin if (row > 0)  tgt = m_tile - 18; end
            else if (d) begin if (row < 10) tgt = m_tile + 18; end
            else if (l) begin if (col > 0)  tgt = m_tile - 1;  end
            else if (r) begin if (col < 17) tgt = m_tile + 1;  end
            if (tgt >= 0) begin
                if (walkable(tgt)) begin
                    m_tile = tgt;
                    m_ms[tgt] = 1'b1;
                    if (m_cnt < 254) m_cnt++;
                    if (m_ck < 5 && tgt == cps[m_ck]) begin
                        m_ck++;
                        if (m_ck == 5) begin
                            m_dn = 1'b1;
                            m_st = 2;
                        end
                    end
                end else begin
                    m_cnt = 255;
                    if (m_fc < 15) m_fc++;
                    m_st = 1;
                    m_tk = 0;
                end
            end
        end else if (m_st == 1) begin
            if (tk) begin
                m_tk++;
                if (m_tk == 30) model_reset(1'b1);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [197:0] obs, input logic [197:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input bit u, d, l, r, tk, rs);
        exp_t e;
        RST = rs; btn_up = u; btn_down = d; btn_left = l; btn_right = r; tick = tk;
        model_update(u, d, l, r, tk, rs);
        e.ms = m_ms; e.cnt = 8'(m_cnt); e.tile = 8'(m_tile);
        e.ck = 3'(m_ck); e.dn = m_dn; e.fc = 4'(m_fc);
        q.push_back(e);
        @(posedge CLK);
        #1;
        RST = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; tick = 0;
        e = q.pop_front();
        chk("mazestate",      mazestate,              e.ms);
        chk("counter",        198'(counter),          198'(e.cnt));
        chk("player_tile",    198'(player_tile),      198'(e.tile));
        chk("checkpoint_idx", 198'(checkpoint_idx),   198'(e.ck));
        chk("done",           198'(done),             198'(e.dn));
        chk("fail_count",     198'(fail_count),       198'(e.fc));
    endtask

    task automatic idle();        step(0, 0, 0, 0, 0, 0); endtask
    task automatic go_up();       step(1, 0, 0, 0, 0, 0); endtask
    task automatic go_down();     step(0, 1, 0, 0, 0, 0); endtask
    task automatic go_left();     step(0, 0, 1, 0, 0, 0); endtask
    task automatic go_right();    step(0, 0, 0, 1, 0, 0); endtask
    task automatic send_tick();   step(0, 0, 0, 0, 1, 0); endtask

    initial begin
        logic [197:0] v;
        m_fc = 0;
        model_reset(1'b0);

        step(0, 0, 0, 0, 0, 1);
        repeat (10) idle();
        v = '0; v[19] = 1'b1;
        chk("rst_tile", 198'(player_tile), 198'(19));
        chk("rst_map", mazestate, v);
        chk("rst_counter", 198'(counter), 198'(0));

        go_right();
        chk("right_tile", 198'(player_tile), 198'(20));
        go_down();
        chk("down_tile", 198'(player_tile), 198'(38));
        chk("down_counter", 198'(counter), 198'(2));
        v[20] = 1'b1; v[38] = 1'b1;
        chk("visited_map", mazestate, v);

        step(1, 0, 1, 1, 0, 0);
        chk("priority_up", 198'(player_tile), 198'(20));
        go_left();

        // Wall hit with a coincident tick that must not count.
        step(1, 0, 0, 0, 1, 0);
        chk("hit_counter", 198'(counter), 198'(255));
        chk("hit_fail", 198'(fail_count), 198'(1));
        chk("hit_tile", 198'(player_tile), 198'(19));
        repeat (29) send_tick();
        chk("hit_29_ticks", 198'(counter), 198'(255));
        send_tick();
        v = '0; v[19] = 1'b1;
        chk("restart_counter", 198'(counter), 198'(0));
        chk("restart_map", mazestate, v);
        chk("restart_fail", 198'(fail_count), 198'(1));

        go_down();
        chk("ck_out_of_order", 198'(checkpoint_idx), 198'(0));
        go_up();
        repeat (12) go_right();
        chk("ck1", 198'(checkpoint_idx), 198'(1));
        repeat (12) go_left();
        go_down();
        chk("ck2", 198'(checkpoint_idx), 198'(2));
        repeat (4) go_down();
        repeat (4) go_right();
        chk("ck3", 198'(checkpoint_idx), 198'(3));
        go_down();
        repeat (8) go_right();
        chk("ck4", 198'(checkpoint_idx), 198'(4));
        repeat (2) go_down();
        repeat (3) go_right();
        chk("ck5", 198'(checkpoint_idx), 198'(5));
        chk("win_done", 198'(done), 198'(1));
        step(1, 1, 1, 1, 1, 0);
        repeat (3) go_left();
        chk("win_frozen", 198'(player_tile), 198'(178));

        step(0, 0, 0, 0, 0, 1);
        repeat (150) begin
            go_right();
            go_left();
        end
        chk("counter_sat", 198'(counter), 198'(254));

        step(1, 0, 0, 0, 1, 0);
        repeat (5) send_tick();
        step(1, 1, 1, 1, 1, 1);
        chk("rst_mid_hit_fail", 198'(fail_count), 198'(0));
        chk("rst_mid_hit_counter", 198'(counter), 198'(0));
        go_right();
        chk("play_after_rst", 198'(player_tile), 198'(20));

        repeat (16) begin
            go_up();
            repeat (30) send_tick();
        end
        chk("fail_sat", 198'(fail_count), 198'(15));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
